// File: rtl/biu_constants_pkg.sv
// Shared bus-interface types: access size and arbiter owner/state encoding.
package biu_constants_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } biu_size_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IM   = 2'd1,
    OWN_DM   = 2'd2
  } biu_arb_owner_t;

endpackage

// File: rtl/biu_arb.sv
// Two-master bus arbiter: instruction and data requesters share one memory bus,
// one transaction outstanding, data favoured with a starvation bound for instructions.
module biu_arb
  import biu_constants_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            im_req,
  input  logic [XLEN-1:0] im_adr,
  output logic            im_ack,
  output logic            im_err,
  output logic [XLEN-1:0] im_q,
  input  logic            dm_req,
  input  logic [XLEN-1:0] dm_adr,
  input  logic [XLEN-1:0] dm_d,
  input  logic            dm_we,
  input  biu_size_t       dm_size,
  output logic            dm_ack,
  output logic            dm_err,
  output logic [XLEN-1:0] dm_q,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_d,
  output logic            mem_we,
  output biu_size_t       mem_size,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [XLEN-1:0] mem_q,
  output logic [1:0]      owner
);

  // Handshake: a requester holds req and its fields until it sees its ack or err;
  // the bus slave answers a held mem_req with one mem_ack/mem_err cycle. A single
  // cycle of ack/err completes the transfer; nothing depends on req falling.

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int BW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  biu_arb_owner_t  state_q, state_d, grant;
  logic [SW-1:0]   starve_q;
  logic [BW-1:0]   busy_cnt_q;
  logic [XLEN-1:0] adr_q, d_q;
  logic            we_q;
  biu_size_t       size_q;
  logic            busy, timeout_hit;

  function automatic biu_arb_owner_t arb_pick(input logic im, input logic dm,
                                              input logic starved);
    biu_arb_owner_t pick;
    pick = OWN_NONE;
    if (dm && !(im && starved)) pick = OWN_DM;
    else if (im)                pick = OWN_IM;
    return pick;
  endfunction

  always_comb begin
    grant       = OWN_NONE;
    state_d     = state_q;
    busy        = (state_q != OWN_NONE);
    timeout_hit = (TIMEOUT != 0) && busy && !mem_ack && !mem_err &&
                  (busy_cnt_q == BW'(TIMEOUT - 1));
    case (state_q)
      OWN_NONE: begin
        grant   = arb_pick(im_req, dm_req, starve_q == SW'(STARVE_LIMIT));
        state_d = grant;
      end
      OWN_IM, OWN_DM: begin
        if (mem_ack || mem_err || timeout_hit) state_d = OWN_NONE;
      end
      default: state_d = OWN_NONE;
    endcase

    // Error wins over ack; strobes are held off while rst is asserted.
    im_ack = !rst && (state_q == OWN_IM) && mem_ack && !mem_err;
    im_err = !rst && (state_q == OWN_IM) && (mem_err || timeout_hit);
    dm_ack = !rst && (state_q == OWN_DM) && mem_ack && !mem_err;
    dm_err = !rst && (state_q == OWN_DM) && (mem_err || timeout_hit);
    im_q   = im_ack ? mem_q : '0;
    dm_q   = dm_ack ? mem_q : '0;

    mem_req  = busy && !rst;
    mem_adr  = mem_req ? adr_q : '0;
    mem_d    = mem_req ? d_q : '0;
    mem_we   = mem_req && we_q;
    mem_size = mem_req ? size_q : BYTE;
  end

  assign owner = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OWN_NONE;
      starve_q   <= '0;
      busy_cnt_q <= '0;
      adr_q      <= '0;
      d_q        <= '0;
      we_q       <= 1'b0;
      size_q     <= BYTE;
    end else begin
      state_q <= state_d;

      if (grant == OWN_DM) begin
        adr_q  <= dm_adr;
        d_q    <= dm_d;
        we_q   <= dm_we;
        size_q <= dm_size;
      end else if (grant == OWN_IM) begin
        adr_q  <= im_adr;
        d_q    <= '0;
        we_q   <= 1'b0;
        size_q <= WORD;
      end

      if (grant != OWN_NONE)                   busy_cnt_q <= '0;
      else if (busy && !mem_ack && !mem_err)   busy_cnt_q <= busy_cnt_q + 1'b1;

      // Counts data grants that overtook a waiting instruction fetch.
      if (grant == OWN_IM)
        starve_q <= '0;
      else if (grant == OWN_DM && im_req && starve_q != SW'(STARVE_LIMIT))
        starve_q <= starve_q + 1'b1;
      else if (state_q == OWN_NONE && !im_req)
        starve_q <= '0;
    end
  end

endmodule

// File: tb/tb_biu_arb.sv
// Directed bench for biu_arb: per-cycle vector table plus hand-written sequences
// for starvation, timeout and reset-abort behaviour.
module tb_biu_arb;
  import biu_constants_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req, im_ack, im_err;
  logic [31:0] im_adr, im_q;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [31:0] dm_adr, dm_d, dm_q;
  biu_size_t   dm_size, mem_size;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_adr, mem_d, mem_q;
  logic [1:0]  owner;

  biu_arb #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_adr(im_adr), .im_ack(im_ack), .im_err(im_err), .im_q(im_q),
    .dm_req(dm_req), .dm_adr(dm_adr), .dm_d(dm_d), .dm_we(dm_we), .dm_size(dm_size),
    .dm_ack(dm_ack), .dm_err(dm_err), .dm_q(dm_q),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_err(mem_err), .mem_q(mem_q),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  ctl;      // {rst, im_req, dm_req, dm_we, mem_ack, mem_err}
    logic [31:0] im_adr;
    logic [31:0] dm_adr;
    logic [31:0] dm_d;
    logic [1:0]  dm_sz;
    logic [31:0] mem_q;
    logic        e_req;
    logic [31:0] e_adr;
    logic [31:0] e_d;
    logic        e_we;
    logic [1:0]  e_sz;
    logic [1:0]  e_own;
    logic [3:0]  e_strb;   // {im_ack, im_err, dm_ack, dm_err}
    logic [31:0] e_im_q;
    logic [31:0] e_dm_q;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin
    int cnt;
    logic [1:0] exp_own;

    rst = 1'b1; im_req = 0; im_adr = 0; dm_req = 0; dm_adr = 0; dm_d = 0;
    dm_we = 0; dm_size = BYTE; mem_ack = 0; mem_err = 0; mem_q = 0;

    //           ctl       im_adr    dm_adr    dm_d          sz    mem_q          req adr       d             we sz    own   strb     im_q          dm_q
    tbl[0]  = '{6'b100000, 32'h0,   32'h0,   32'h0,        2'd0, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[1]  = '{6'b100000, 32'h0,   32'h0,   32'h0,        2'd0, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[2]  = '{6'b001100, 32'h0,   32'h100, 32'hDEADBEEF, 2'd2, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[3]  = '{6'b001100, 32'h0,   32'h100, 32'hDEADBEEF, 2'd2, 32'h0,        1, 32'h100, 32'hDEADBEEF, 1, 2'd2, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[4]  = '{6'b001100, 32'h0,   32'h100, 32'hDEADBEEF, 2'd2, 32'h0,        1, 32'h100, 32'hDEADBEEF, 1, 2'd2, 2'd2, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{6'b001110, 32'h0,   32'h100, 32'hDEADBEEF, 2'd2, 32'hCAFEF00D, 1, 32'h100, 32'hDEADBEEF, 1, 2'd2, 2'd2, 4'b0010, 32'h0,        32'hCAFEF00D};
    tbl[6]  = '{6'b000000, 32'h0,   32'h0,   32'h0,        2'd0, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[7]  = '{6'b010000, 32'h200, 32'h0,   32'h0,        2'd0, 32'h12345678, 0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[8]  = '{6'b010000, 32'h200, 32'h0,   32'h0,        2'd0, 32'h12345678, 1, 32'h200, 32'h0,        0, 2'd2, 2'd1, 4'b0000, 32'h0,        32'h0};
    tbl[9]  = '{6'b010010, 32'h200, 32'h0,   32'h0,        2'd0, 32'h12345678, 1, 32'h200, 32'h0,        0, 2'd2, 2'd1, 4'b1000, 32'h12345678, 32'h0};
    tbl[10] = '{6'b000010, 32'h0,   32'h0,   32'h0,        2'd0, 32'h12345678, 0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[11] = '{6'b001000, 32'h0,   32'h300, 32'h55,       2'd0, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};
    tbl[12] = '{6'b001011, 32'h0,   32'h300, 32'h55,       2'd0, 32'hAAAA5555, 1, 32'h300, 32'h55,       0, 2'd0, 2'd2, 4'b0001, 32'h0,        32'h0};
    tbl[13] = '{6'b000001, 32'h0,   32'h0,   32'h0,        2'd0, 32'h0,        0, 32'h0,   32'h0,        0, 2'd0, 2'd0, 4'b0000, 32'h0,        32'h0};

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      {rst, im_req, dm_req, dm_we, mem_ack, mem_err} = tbl[i].ctl;
      im_adr  = tbl[i].im_adr;
      dm_adr  = tbl[i].dm_adr;
      dm_d    = tbl[i].dm_d;
      dm_size = biu_size_t'(tbl[i].dm_sz);
      mem_q   = tbl[i].mem_q;
      @(negedge clk);
      check($sformatf("r%0d mem_req", i),  {31'b0, mem_req},         {31'b0, tbl[i].e_req});
      check($sformatf("r%0d mem_adr", i),  mem_adr,                  tbl[i].e_adr);
      check($sformatf("r%0d mem_d", i),    mem_d,                    tbl[i].e_d);
      check($sformatf("r%0d mem_we", i),   {31'b0, mem_we},          {31'b0, tbl[i].e_we});
      check($sformatf("r%0d mem_size", i), {30'b0, mem_size},        {30'b0, tbl[i].e_sz});
      check($sformatf("r%0d owner", i),    {30'b0, owner},           {30'b0, tbl[i].e_own});
      check($sformatf("r%0d strobes", i),
            {28'b0, im_ack, im_err, dm_ack, dm_err}, {28'b0, tbl[i].e_strb});
      check($sformatf("r%0d im_q", i),     im_q,                     tbl[i].e_im_q);
      check($sformatf("r%0d dm_q", i),     dm_q,                     tbl[i].e_dm_q);
    end

    // Both masters requesting continuously, ack every busy cycle.
    rst = 0; im_req = 1; dm_req = 1; im_adr = 32'h400; dm_adr = 32'h500;
    dm_d = 32'h0; dm_we = 0; dm_size = WORD; mem_ack = 1; mem_err = 0; mem_q = 32'h0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      if (cnt == 4) begin exp_own = 2'd1; cnt = 0; end
      else begin exp_own = 2'd2; cnt = cnt + 1; end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("starve t%0d owner", t), {30'b0, owner}, {30'b0, exp_own});
      check($sformatf("starve t%0d adr", t), mem_adr, (exp_own == 2'd1) ? 32'h400 : 32'h500);
      check($sformatf("starve t%0d ack", t), {30'b0, im_ack, dm_ack},
            (exp_own == 2'd1) ? 32'd2 : 32'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("starve t%0d idle", t), {30'b0, owner}, 32'd0);
    end
    im_req = 0; dm_req = 0; mem_ack = 0;

    // Instruction fetch with no response: error on the 8th busy cycle.
    im_req = 1; im_adr = 32'h600;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("tmo k%0d mem_req", k), {31'b0, mem_req}, 32'd1);
      check($sformatf("tmo k%0d im_err", k), {31'b0, im_err}, (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("tmo k%0d im_ack", k), {31'b0, im_ack}, 32'd0);
      if (k == 8) im_req = 0;
      @(posedge clk);
    end
    @(negedge clk);
    check("tmo after mem_req", {31'b0, mem_req}, 32'd0);
    check("tmo after owner", {30'b0, owner}, 32'd0);
    mem_ack = 1;
    #1;
    check("tmo late ack strobes", {28'b0, im_ack, im_err, dm_ack, dm_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 0;
    check("tmo late ack owner", {30'b0, owner}, 32'd0);

    // Reset pulsed while an instruction fetch is outstanding.
    im_req = 1; im_adr = 32'h700;
    @(posedge clk);
    @(negedge clk);
    check("rst pre owner", {30'b0, owner}, 32'd1);
    rst = 1; mem_ack = 1; im_req = 0;
    #1;
    check("rst during strobes", {28'b0, im_ack, im_err, dm_ack, dm_err}, 32'd0);
    check("rst during mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst after owner", {30'b0, owner}, 32'd0);
    check("rst after mem_req", {31'b0, mem_req}, 32'd0);
    check("rst after strobes", {28'b0, im_ack, im_err, dm_ack, dm_err}, 32'd0);
    mem_ack = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst settle owner", {30'b0, owner}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
